link_word_aligner: RTL and testbench

- Sits directly downstream of the IO block's per-link out_tdata/out_tvalid stream, which carries 8 raw bits per clk160 at an arbitrary bit phase.
- Finds the bit offset (0..7) at which a known training byte appears, then confirms and locks to that offset.
- Emits byte-aligned data on an AXI-stream master through a 4-entry first-word-fall-through FIFO.
- One instance per link.

---
 rtl/link_word_aligner_pkg.sv | 43 ++++
 rtl/link_word_aligner_if.sv | 18 +
 rtl/link_word_aligner_fifo.sv | 66 ++++++
 rtl/link_word_aligner.sv | 174 +++++++++++++++++
 tb/tb_link_word_aligner.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_word_aligner_pkg.sv
// -----------------------------------------------------------------------------
// link_align_pkg
// Shared types and helpers for the per-link word aligner.
//   align_state_t   : SEARCH / CONFIRM / LOCKED alignment state
//   hit_t           : result of a pattern search over the 16-bit window
//   cand_at()       : byte starting k bits into the window (bit 15 = earliest)
//   find_first_hit(): lowest offset k at which the pattern appears
// -----------------------------------------------------------------------------
package link_align_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] k;
    } hit_t;

    // Candidate k is window bits [15-k : 8-k]; shifting left by k moves them
    // to the top byte.
    function automatic logic [7:0] cand_at(input logic [15:0] win, input logic [2:0] k);
        logic [15:0] sh;
        sh = win << k;
        return sh[15:8];
    endfunction

    // Scan from the highest offset down so the lowest matching k is kept.
    function automatic hit_t find_first_hit(input logic [15:0] win, input logic [7:0] pattern);
        hit_t r;
        r = '{found: 1'b0, k: 3'd0};
        for (int k = 7; k >= 0; k--) begin
            if (cand_at(win, 3'(k)) == pattern) begin
                r.found = 1'b1;
                r.k     = 3'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/link_word_aligner_if.sv
// -----------------------------------------------------------------------------
// link_axis_if
// Minimal AXI-stream bundle used for both the raw input and aligned output.
//   tdata  : payload byte
//   tvalid : payload qualifier
//   tready : sink accept
// master drives tdata/tvalid, slave drives tready.
// -----------------------------------------------------------------------------
interface link_axis_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/link_word_aligner_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO.
//   clk160, reset : clock, asynchronous active-high reset
//   flush         : synchronous empty; beats a same-cycle write
//   wr_en/wr_data : write request (dropped when full and no read)
//   rd_en/rd_data : read/accept; rd_data shows the head entry, 0 when empty
//   full, empty   : occupancy flags
//   wr_overflow   : one-cycle pulse when a write is dropped
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk160,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             wr_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_fire;
    logic             wr_fire;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    // A read in the same cycle frees the slot, so a write to a full FIFO is
    // still accepted then.
    assign wr_fire     = wr_en && (!full || rd_fire) && !flush;
    assign wr_overflow = wr_en && full && !rd_fire && !flush;

    // Gating on empty keeps stale entries off the output after reset/flush.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; pointers define validity, and
    // leaving the array out of reset lets it map onto plain RAM/flops.
    always_ff @(posedge clk160) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/link_word_aligner.sv
// -----------------------------------------------------------------------------
// link_word_aligner
// Finds the bit phase of a training byte in a raw 8-bit/clk160 link stream,
// confirms and locks to it, and emits byte-aligned data through a FWFT FIFO.
//   clk160, reset     : clock, asynchronous active-high reset
//   in_axis (slave)   : raw bytes, bit 7 earliest; tready tied high
//   out_axis (master) : aligned bytes, tvalid = FIFO not empty
//   resync            : pulse; back to SEARCH, FIFO flushed
//   clear_status      : pulse; clears lock_loss_count and overflow
//   locked            : state is LOCKED
//   bit_offset        : selected offset 0..7
//   lock_loss_count   : saturating count of LOCKED->SEARCH drops
//   overflow          : sticky, FIFO write attempted while full
// -----------------------------------------------------------------------------
module link_word_aligner
    import link_align_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = 8'hAC,
    parameter int         LOCK_COUNT   = 16,
    parameter int         UNLOCK_COUNT = 4,
    parameter bit         DROP_IDLE    = 1'b0,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic              clk160,
    input  logic              reset,
    link_axis_if.slave        in_axis,
    link_axis_if.master       out_axis,
    input  logic              resync,
    input  logic              clear_status,
    output logic              locked,
    output logic [2:0]        bit_offset,
    output logic [7:0]        lock_loss_count,
    output logic              overflow
);
    localparam logic [7:0] LOCK_CNT8   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_CNT8 = 8'(UNLOCK_COUNT);

    align_state_t state;
    logic [7:0]   prev;
    logic [15:0]  win;
    hit_t         first_hit;
    logic [7:0]   cand_sel;
    logic         hit_sel;
    logic [7:0]   match_cnt;
    logic [7:0]   miss_cnt;
    logic [7:0]   aligned;
    logic         wr_en;
    logic         lock_lost;
    logic         fifo_ovf;
    logic         fifo_empty;
    logic         unused_fifo_full;

    assign in_axis.tready = 1'b1;

    assign win       = {prev, in_axis.tdata};
    assign first_hit = find_first_hit(win, SYNC_PATTERN);
    assign cand_sel  = cand_at(win, bit_offset);
    assign hit_sel   = (cand_sel == SYNC_PATTERN);

    // Lock drops only on a sync seen at a foreign offset; plain payload that
    // matches nowhere leaves the miss counter alone.
    assign lock_lost = in_axis.tvalid && !resync && (state == LOCKED) && !hit_sel &&
                       first_hit.found && (miss_cnt + 8'd1 == UNLOCK_CNT8);

    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            bit_offset <= 3'd0;
            match_cnt  <= 8'd0;
            miss_cnt   <= 8'd0;
        end else if (resync) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            match_cnt <= 8'd0;
            miss_cnt  <= 8'd0;
        end else if (in_axis.tvalid) begin
            case (state)
                SEARCH: begin
                    if (first_hit.found) begin
                        bit_offset <= first_hit.k;
                        match_cnt  <= 8'd1;
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (hit_sel) begin
                        match_cnt <= match_cnt + 8'd1;
                        if (match_cnt + 8'd1 == LOCK_CNT8) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        // Re-search starts with the next valid byte.
                        match_cnt <= 8'd0;
                        state     <= SEARCH;
                    end
                end
                LOCKED: begin
                    if (hit_sel) begin
                        miss_cnt <= 8'd0;
                    end else if (lock_lost) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        miss_cnt  <= 8'd0;
                        match_cnt <= 8'd0;
                    end else if (first_hit.found) begin
                        miss_cnt <= miss_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // The write decision uses the pre-edge state, so the byte that completes
    // the lock is not written.
    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            prev    <= 8'd0;
            aligned <= 8'd0;
            wr_en   <= 1'b0;
        end else begin
            wr_en <= in_axis.tvalid && !resync && (state == LOCKED) &&
                     !(DROP_IDLE && (cand_sel == SYNC_PATTERN));
            if (in_axis.tvalid) begin
                prev    <= in_axis.tdata;
                aligned <= cand_sel;
            end
        end
    end

    // clear_status wins over a same-cycle lock loss or overflow event.
    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            lock_loss_count <= 8'd0;
            overflow        <= 1'b0;
        end else if (clear_status) begin
            lock_loss_count <= 8'd0;
            overflow        <= 1'b0;
        end else begin
            if (lock_lost && (lock_loss_count != 8'hFF)) lock_loss_count <= lock_loss_count + 8'd1;
            if (fifo_ovf) overflow <= 1'b1;
        end
    end

    // resync flushes the FIFO and squashes the write already in flight.
    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk160      (clk160),
        .reset       (reset),
        .flush       (resync),
        .wr_en       (wr_en),
        .wr_data     (aligned),
        .rd_en       (out_axis.tready),
        .rd_data     (out_axis.tdata),
        .full        (unused_fifo_full),
        .empty       (fifo_empty),
        .wr_overflow (fifo_ovf)
    );

    assign out_axis.tvalid = !fifo_empty;

endmodule

// File: tb/tb_link_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_link_word_aligner
// Directed scenarios plus a randomized phase, checked every cycle against a
// behavioural model built from bit arithmetic on the raw window and a queue
// standing in for the output FIFO.
// -----------------------------------------------------------------------------
module tb_link_word_aligner;

    localparam logic [7:0] SYNC     = 8'hAC;
    localparam int         LOCK_N   = 16;
    localparam int         UNLOCK_N = 4;
    localparam bit         DROP     = 1'b0;
    localparam int         DEPTH    = 4;

    logic       clk160 = 1'b0;
    logic       reset  = 1'b1;
    logic       resync = 1'b0;
    logic       clear_status = 1'b0;
    logic       locked;
    logic [2:0] bit_offset;
    logic [7:0] lock_loss_count;
    logic       overflow;

    link_axis_if #(.WIDTH(8)) in_if ();
    link_axis_if #(.WIDTH(8)) out_if ();

    always #5 clk160 = ~clk160;

    link_word_aligner #(
        .SYNC_PATTERN (SYNC),
        .LOCK_COUNT   (LOCK_N),
        .UNLOCK_COUNT (UNLOCK_N),
        .DROP_IDLE    (DROP),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk160          (clk160),
        .reset           (reset),
        .in_axis         (in_if),
        .out_axis        (out_if),
        .resync          (resync),
        .clear_status    (clear_status),
        .locked          (locked),
        .bit_offset      (bit_offset),
        .lock_loss_count (lock_loss_count),
        .overflow        (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    bit         m_lock;
    int         m_run;      // matches collected at m_off; 0 while searching
    int         m_off;
    int         m_miss;
    int         m_loss;
    bit         m_ovf;
    logic [7:0] m_prev;
    logic [7:0] q[$];
    bit         pend_v;
    logic [7:0] pend_b;

    // Stimulus generator: aligned byte stream delayed by gen_k bits.
    logic [7:0] gen_prev = SYNC;
    int         gen_k    = 3;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int cand(input logic [7:0] p, input logic [7:0] d, input int k);
        int w;
        w = int'(p) * 256 + int'(d);
        return (w >> (8 - k)) % 256;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_run = 0; m_off = 0; m_miss = 0; m_loss = 0; m_ovf = 0;
        m_prev = 8'd0; q.delete(); pend_v = 0; pend_b = 8'd0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit rdy, input bit rs, input bit clr);
        bit fire, ovf_ev, loss_ev, new_pv;
        int first, c_off;
        fire    = (q.size() > 0) && rdy;
        ovf_ev  = 0;
        loss_ev = 0;
        first   = -1;
        for (int k = 0; k < 8; k++)
            if (first < 0 && cand(m_prev, d, k) == int'(SYNC)) first = k;
        c_off = cand(m_prev, d, m_off);

        if (rs) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (pend_v) begin
                if (q.size() < DEPTH) q.push_back(pend_b);
                else ovf_ev = 1;
            end
        end

        new_pv = v && m_lock && !rs && !(DROP && c_off == int'(SYNC));
        if (v) pend_b = 8'(c_off);
        pend_v = new_pv;

        if (rs) begin
            m_lock = 0; m_run = 0; m_miss = 0;
        end else if (v) begin
            if (m_lock) begin
                if (c_off == int'(SYNC)) m_miss = 0;
                else if (first >= 0) begin
                    m_miss++;
                    if (m_miss == UNLOCK_N) begin
                        m_lock = 0; m_run = 0; m_miss = 0; loss_ev = 1;
                    end
                end
            end else if (m_run == 0) begin
                if (first >= 0) begin
                    m_off = first; m_run = 1; m_lock = (m_run >= LOCK_N);
                end
            end else if (c_off == int'(SYNC)) begin
                m_run++; m_lock = (m_run >= LOCK_N);
            end else m_run = 0;
        end
        if (v) m_prev = d;

        if (clr) begin
            m_loss = 0; m_ovf = 0;
        end else begin
            if (loss_ev && m_loss < 255) m_loss++;
            if (ovf_ev) m_ovf = 1;
        end
    endtask

    task automatic compare_outputs();
        check("locked", locked, m_lock);
        check("bit_offset", bit_offset, m_off);
        check("lock_loss_count", lock_loss_count, m_loss);
        check("overflow", overflow, m_ovf);
        check("out_tvalid", out_if.tvalid, q.size() > 0);
        if (q.size() > 0) check("out_tdata", out_if.tdata, q[0]);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, input bit rs, input bit clr);
        in_if.tvalid  = v;
        in_if.tdata   = d;
        out_if.tready = rdy;
        resync        = rs;
        clear_status  = clr;
        @(posedge clk160);
        model_edge(v, d, rdy, rs, clr);
        #1;
        compare_outputs();
    endtask

    task automatic send(input logic [7:0] a, input bit rdy, input bit rs = 1'b0, input bit clr = 1'b0);
        logic [15:0] t;
        t = {gen_prev, a} >> gen_k;
        gen_prev = a;
        cycle(1'b1, t[7:0], rdy, rs, clr);
    endtask

    task automatic gap(input bit rdy);
        cycle(1'b0, 8'($urandom), rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        in_if.tvalid = 1'b0; out_if.tready = 1'b1; resync = 1'b0; clear_status = 1'b0;
        model_reset();
        #1;
        check({tag, "_out_tvalid"}, out_if.tvalid, 0);
        check({tag, "_out_tdata"}, out_if.tdata, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_bit_offset"}, bit_offset, 0);
        check({tag, "_lock_loss_count"}, lock_loss_count, 0);
        check({tag, "_overflow"}, overflow, 0);
        @(negedge clk160);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_if.tdata = 8'd0;
        do_reset("reset");
        check("in_tready", in_if.tready, 1);

        // Rotated training stream: the first window holds prev=0 so no hit;
        // the 16th hit afterwards completes the lock.
        gen_k = 3; gen_prev = SYNC;
        for (int i = 0; i <= 16; i++) begin
            send(SYNC, 1'b1);
            check("lock_timing", locked, (i == 16));
        end
        check("lock_offset3", bit_offset, 3);
        for (int i = 0; i < 3; i++) send(SYNC, 1'b1);
        check("idle_out_valid", out_if.tvalid, 1);
        check("idle_out_data", out_if.tdata, SYNC);

        // Payload 00,11..FF at the locked offset.
        for (int i = 0; i < 16; i++) send(8'(i * 17), 1'b1);
        for (int i = 0; i < 3; i++) send(SYNC, 1'b1);
        check("payload_locked", locked, 1);

        // Move the stream to offset 5: lock drops, then re-locks there.
        gen_k = 5;
        n = 0;
        while (locked === 1'b1 && n < 12) begin send(SYNC, 1'b1); n++; end
        check("unlock_locked", locked, 0);
        check("unlock_loss_count", lock_loss_count, 1);
        n = 0;
        while (locked !== 1'b1 && n < 40) begin send(SYNC, 1'b1); n++; end
        check("relock_locked", locked, 1);
        check("relock_offset5", bit_offset, 5);

        // resync while LOCKED with two bytes queued.
        for (int i = 0; i < 10 && q.size() < 2; i++) send(SYNC, 1'b0);
        check("resync_fifo_fill", out_if.tvalid, 1);
        send(SYNC, 1'b0, 1'b1, 1'b0);
        check("resync_out_tvalid", out_if.tvalid, 0);
        check("resync_locked", locked, 0);
        check("resync_loss_count", lock_loss_count, 1);
        n = 0;
        while (locked !== 1'b1 && n < 40) begin send(SYNC, 1'b1); n++; end
        check("resync_relock", locked, 1);

        // Stall the output for 10 valid bytes, then drain and clear.
        for (int i = 0; i < 10; i++) send(8'(i + 1), 1'b0);
        check("stall_overflow", overflow, 1);
        check("stall_out_tvalid", out_if.tvalid, 1);
        for (int i = 0; i < 6; i++) send(SYNC, 1'b1);
        send(SYNC, 1'b1, 1'b0, 1'b1);
        check("clear_overflow", overflow, 0);
        check("clear_loss_count", lock_loss_count, 0);

        // CONFIRM broken by a wrong byte at cycle 8.
        do_reset("reset2");
        gen_k = 3;
        for (int i = 0; i < 8; i++) send(SYNC, 1'b1);
        send(8'h00, 1'b1);
        for (int i = 9; i <= 16; i++) send(SYNC, 1'b1);
        check("confirm_break_locked", locked, 0);
        n = 0;
        while (locked !== 1'b1 && n < 40) begin send(SYNC, 1'b1); n++; end
        check("confirm_break_relock", locked, 1);
        check("confirm_break_offset", bit_offset, 3);

        // Asynchronous reset while LOCKED with two bytes queued.
        for (int i = 0; i < 10 && q.size() < 2; i++) send(SYNC, 1'b0);
        check("reset_fifo_fill", out_if.tvalid, 1);
        do_reset("reset3");

        // Randomized traffic: gaps, stalls, offset changes, resync, clears.
        for (int i = 0; i < 600; i++) begin
            bit rdy;
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) gen_k = $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) gap(rdy);
            else if ($urandom_range(0, 9) < 6) send(SYNC, rdy, ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
            else send(8'($urandom), rdy, 1'b0, ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
